// File: rtl/e_bus_timer.sv
// VIA-style 16-bit interval timer on the 6809 E/Q bus: reload latch, one-shot or
// free-running countdown, interrupt flag and active-low IRQ.
module e_bus_timer #(
    parameter logic [15:0] RESET_LATCH = 16'hFFFF,
    parameter bit          IRQ_REG     = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       riseE,
    input  logic       fallE,
    input  logic       CS,
    input  logic [1:0] ADDR,
    input  logic       RnW,
    input  logic [7:0] Din,
    output logic [7:0] Dout,
    output logic       nIRQ
);

    logic [15:0] latch;
    logic [15:0] counter;
    logic        irqEnable;
    logic        freeRun;
    logic        intFlag;
    logic        armed;

    logic       busWrite;
    logic       wrLo;
    logic       wrHi;
    logic       wrCtl;
    logic       wrStat;
    logic       rdLo;
    logic       underflow;
    logic       setFlag;
    logic       clrFlag;
    logic       irqComb;
    logic [7:0] readMux;

    // Bus side effects only ever happen on the fallE strobe.
    assign busWrite  = fallE & CS & ~RnW;
    assign wrLo      = busWrite & (ADDR == 2'd0);
    assign wrHi      = busWrite & (ADDR == 2'd1);
    assign wrCtl     = busWrite & (ADDR == 2'd2);
    assign wrStat    = busWrite & (ADDR == 2'd3);
    assign rdLo      = fallE & CS & RnW & (ADDR == 2'd0);
    assign underflow = fallE & (counter == 16'h0000);
    assign setFlag   = underflow & (freeRun | armed);
    assign clrFlag   = rdLo | (wrStat & Din[7]);
    assign irqComb   = ~(intFlag & irqEnable);

    always_comb begin
        readMux = 8'h00;
        case (ADDR)
            2'd0:    readMux = counter[7:0];
            2'd1:    readMux = counter[15:8];
            2'd2:    readMux = {6'b0, freeRun, irqEnable};
            default: readMux = {intFlag, 6'b0, armed};
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            latch     <= RESET_LATCH;
            counter   <= RESET_LATCH;
            irqEnable <= 1'b0;
            freeRun   <= 1'b0;
            intFlag   <= 1'b0;
            armed     <= 1'b0;
            Dout      <= 8'h00;
        end else begin
            if (riseE && CS && RnW)
                Dout <= readMux;
            if (wrLo)
                latch[7:0] <= Din;
            if (wrHi)
                latch[15:8] <= Din;
            if (wrCtl) begin
                irqEnable <= Din[0];
                freeRun   <= Din[1];
            end
            // Reload uses the latch as it stood before this strobe's writes.
            if (fallE) begin
                if (wrHi)
                    counter <= {Din, latch[7:0]};
                else if (counter == 16'h0000)
                    counter <= freeRun ? latch : 16'hFFFF;
                else
                    counter <= counter - 16'd1;
            end
            // Load beats underflow, underflow beats any clear.
            if (wrHi)
                intFlag <= 1'b0;
            else if (setFlag)
                intFlag <= 1'b1;
            else if (clrFlag)
                intFlag <= 1'b0;
            if (wrHi)
                armed <= 1'b1;
            else if (underflow && !freeRun)
                armed <= 1'b0;
        end
    end

    generate
        if (IRQ_REG) begin : gRegIrq
            logic irqQ;
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET)
                    irqQ <= 1'b1;
                else
                    irqQ <= irqComb;
            end
            assign nIRQ = irqQ;
        end else begin : gCombIrq
            assign nIRQ = irqComb;
        end
    endgenerate

endmodule

// File: tb/tb_e_bus_timer.sv
// Directed bench for e_bus_timer: a transaction-level register model checked against
// Dout/nIRQ on every cycle, plus hand-computed literal read-backs.
module tb_e_bus_timer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       riseE;
    logic       fallE;
    logic       CS;
    logic [1:0] ADDR;
    logic       RnW;
    logic [7:0] Din;
    logic [7:0] Dout;
    logic       nIRQ;

    e_bus_timer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .riseE (riseE),
        .fallE (fallE),
        .CS    (CS),
        .ADDR  (ADDR),
        .RnW   (RnW),
        .Din   (Din),
        .Dout  (Dout),
        .nIRQ  (nIRQ)
    );

    always #5 CLK = ~CLK;

    // Register model: state of the timer as seen by the CPU.
    logic [15:0] mCount;
    logic [15:0] mLatch;
    logic        mIE;
    logic        mFree;
    logic        mIF;
    logic        mArmed;
    logic [7:0]  mDout;
    logic        pIF = 1'b0;
    logic        pIE = 1'b0;
    logic        expN;
    bit          running = 1'b0;
    int          nCompared = 0;
    int          nFailed = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        mCount = 16'hFFFF;
        mLatch = 16'hFFFF;
        mIE    = 1'b0;
        mFree  = 1'b0;
        mIF    = 1'b0;
        mArmed = 1'b0;
        mDout  = 8'h00;
    endtask

    function automatic logic [7:0] modelRead(input logic [1:0] a);
        case (a)
            2'd0:    return mCount[7:0];
            2'd1:    return mCount[15:8];
            2'd2:    return {6'b0, mFree, mIE};
            default: return {mIF, 6'b0, mArmed};
        endcase
    endfunction

    // One fallE: events are evaluated against the state before the strobe,
    // then resolved by priority (load > underflow set > clear).
    task automatic modelFall(input logic cs, input logic [1:0] a, input logic rnw,
                             input logic [7:0] d);
        logic        isLoad;
        logic        isUnder;
        logic        raise;
        logic        clear;
        logic [15:0] oldLatch;
        logic        oldFree;
        isLoad   = cs && !rnw && (a == 2'd1);
        isUnder  = (mCount == 16'h0000);
        raise    = isUnder && (mFree || mArmed);
        clear    = cs && ((rnw && a == 2'd0) || (!rnw && a == 2'd3 && d[7]));
        oldLatch = mLatch;
        oldFree  = mFree;
        if (cs && !rnw) begin
            case (a)
                2'd0:    mLatch[7:0] = d;
                2'd1:    mLatch[15:8] = d;
                2'd2:    begin mIE = d[0]; mFree = d[1]; end
                default: ;
            endcase
        end
        if (isLoad)
            mCount = {d, oldLatch[7:0]};
        else if (isUnder)
            mCount = oldFree ? oldLatch : 16'hFFFF;
        else
            mCount = mCount - 16'd1;
        if (isLoad) begin
            mIF    = 1'b0;
            mArmed = 1'b1;
        end else begin
            if (raise)
                mIF = 1'b1;
            else if (clear)
                mIF = 1'b0;
            if (isUnder && !oldFree)
                mArmed = 1'b0;
        end
    endtask

    task automatic busCycle(input logic cs, input logic [1:0] a, input logic rnw,
                            input logic [7:0] d);
        @(posedge CLK); #1;
        CS = cs; ADDR = a; RnW = rnw; Din = d; riseE = 1'b1;
        @(posedge CLK); #1;
        riseE = 1'b0;
        if (cs && rnw)
            mDout = modelRead(a);
        @(posedge CLK); #1;
        fallE = 1'b1;
        @(posedge CLK); #1;
        fallE = 1'b0;
        modelFall(cs, a, rnw, d);
        CS = 1'b0;
    endtask

    // Back-to-back fallE strobes with no chip select: pure counting.
    task automatic idleFalls(input int n);
        @(posedge CLK); #1;
        CS = 1'b0; fallE = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            modelFall(1'b0, 2'd0, 1'b1, 8'h00);
        end
        fallE = 1'b0;
    endtask

    task automatic checkIrqNextClk(input string name);
        @(posedge CLK); #1;
        check(name, 16'(nIRQ), 16'h0000);
    endtask

    // nIRQ is the registered view of the previous cycle's flag and enable.
    always @(negedge CLK) begin
        if (running) begin
            expN = RESET ? 1'b1 : ~(pIF & pIE);
            check("dout_model", 16'(Dout), 16'(mDout));
            check("nirq_model", 16'(nIRQ), 16'(expN));
            pIF = RESET ? 1'b0 : mIF;
            pIE = RESET ? 1'b0 : mIE;
        end
    end

    initial begin
        RESET = 1'b1; riseE = 1'b0; fallE = 1'b0; CS = 1'b0;
        ADDR = 2'd0; RnW = 1'b1; Din = 8'h00;
        modelReset();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_dout", 16'(Dout), 16'h0000);
        check("reset_nirq", 16'(nIRQ), 16'h0001);
        RESET = 1'b0;
        running = 1'b1;

        busCycle(1, 2'd3, 1, 8'h00);
        check("reset_status", 16'(Dout), 16'h0000);
        busCycle(1, 2'd1, 1, 8'h00);
        check("reset_cnt_hi", 16'(Dout), 16'h00FF);

        // One-shot, load 0003.
        busCycle(1, 2'd2, 0, 8'h01);
        busCycle(1, 2'd0, 0, 8'h03);
        busCycle(1, 2'd1, 0, 8'h00);
        busCycle(1, 2'd0, 1, 8'h00);
        check("os_cnt3", 16'(Dout), 16'h0003);
        busCycle(1, 2'd0, 1, 8'h00);
        check("os_cnt2", 16'(Dout), 16'h0002);
        busCycle(1, 2'd0, 1, 8'h00);
        check("os_cnt1", 16'(Dout), 16'h0001);
        busCycle(1, 2'd3, 1, 8'h00);
        check("os_stat_armed", 16'(Dout), 16'h0001);
        checkIrqNextClk("os_irq_low");
        busCycle(1, 2'd3, 1, 8'h00);
        check("os_stat_if", 16'(Dout), 16'h0080);
        busCycle(1, 2'd0, 1, 8'h00);
        check("os_cnt_fe", 16'(Dout), 16'h00FE);
        idleFalls(65540);
        busCycle(1, 2'd3, 1, 8'h00);
        check("os_no_second_irq", 16'(Dout), 16'h0000);

        // Free-run with latch 0002.
        busCycle(1, 2'd0, 0, 8'h02);
        busCycle(1, 2'd2, 0, 8'h03);
        busCycle(1, 2'd1, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            busCycle(1, 2'd3, 0, 8'h80);
            busCycle(1, 2'd0, 1, 8'h00);
            check("fr_cnt1", 16'(Dout), 16'h0001);
            busCycle(1, 2'd3, 1, 8'h00);
            check("fr_stat", 16'(Dout), 16'h0001);
            checkIrqNextClk("fr_irq_low");
        end
        busCycle(1, 2'd3, 0, 8'h80);
        busCycle(1, 2'd0, 1, 8'h00);
        busCycle(1, 2'd0, 0, 8'h05);
        checkIrqNextClk("fr_latch_wr_irq");
        busCycle(1, 2'd0, 1, 8'h00);
        check("fr_old_reload", 16'(Dout), 16'h0002);
        busCycle(1, 2'd0, 1, 8'h00);
        busCycle(1, 2'd0, 1, 8'h00);
        check("fr_rd_at_under", 16'(Dout), 16'h0000);
        checkIrqNextClk("fr_rd_under_irq");
        busCycle(1, 2'd3, 1, 8'h00);
        check("fr_stat_if", 16'(Dout), 16'h0081);
        busCycle(1, 2'd0, 1, 8'h00);
        check("fr_new_reload", 16'(Dout), 16'h0004);

        // One-shot, load on the same strobe as underflow.
        busCycle(1, 2'd2, 0, 8'h01);
        busCycle(1, 2'd0, 0, 8'h01);
        busCycle(1, 2'd1, 0, 8'h00);
        busCycle(1, 2'd0, 1, 8'h00);
        busCycle(1, 2'd1, 0, 8'h00);
        busCycle(1, 2'd3, 1, 8'h00);
        check("ld_under_stat", 16'(Dout), 16'h0001);
        busCycle(1, 2'd0, 1, 8'h00);
        check("ld_under_cnt", 16'(Dout), 16'h0000);
        checkIrqNextClk("ld_rd_under_irq");

        // Deselected and unstrobed accesses change nothing.
        busCycle(0, 2'd2, 0, 8'h00);
        @(posedge CLK); #1;
        CS = 1'b1; RnW = 1'b0; ADDR = 2'd2; Din = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        CS = 1'b0; RnW = 1'b1;
        busCycle(1, 2'd2, 1, 8'h00);
        check("ctl_unchanged", 16'(Dout), 16'h0001);
        busCycle(0, 2'd1, 1, 8'h00);
        check("dout_holds", 16'(Dout), 16'h0001);
        busCycle(1, 2'd2, 0, 8'h00);
        busCycle(1, 2'd3, 1, 8'h00);
        check("ie_off_if_kept", 16'(Dout), 16'h0080);

        // Reset in the middle of an active interrupt.
        busCycle(1, 2'd2, 0, 8'h01);
        checkIrqNextClk("pre_reset_irq");
        @(posedge CLK); #3;
        RESET = 1'b1;
        modelReset();
        #1;
        check("midrst_nirq", 16'(nIRQ), 16'h0001);
        check("midrst_dout", 16'(Dout), 16'h0000);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        busCycle(1, 2'd1, 1, 8'h00);
        check("post_rst_hi", 16'(Dout), 16'h00FF);
        busCycle(1, 2'd3, 1, 8'h00);
        check("post_rst_stat", 16'(Dout), 16'h0000);

        @(posedge CLK); #1;
        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/e_bus_timer.md
Name: e_bus_timer

Overview:
- Peripheral-side responder for the 6809 E/Q bus: a VIA-style 16-bit interval timer with latch, interrupt flag and active-low IRQ.
- Sits on the CPU data/address bus beside RAM/ROM decode.
- Qualifies all accesses with the CPU wrapper's riseE/fallE strobes. Drives nIRQ back into the CPU.
- Provides one-shot and free-running modes with a reload latch.

Parameters:
RESET_LATCH, 16'hFFFF, latch and counter value after reset
IRQ_REG, 1, 1 = nIRQ output registered (one CLK delay); 0 = combinational from IF&IE

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
riseE  in  1  one-CLK strobe at E rising edge
fallE  in  1  one-CLK strobe at E falling edge; all bus writes, read side-effects and counting happen here
CS  in  1  chip select from address decoder, active high
ADDR  in  2  register select
RnW  in  1  1 = read, 0 = write
Din  in  8  CPU write data
Dout  out  8  read data, valid from riseE until next riseE
nIRQ  out  1  active-low interrupt request to CPU

Behaviour:
- Registers, decoded as ADDR:
  - 0: read counter[7:0] (side effect: clear IF); write latch[7:0].
  - 1: read counter[15:8]; write latch[15:8], then load counter <= {Din, latch[7:0]}, clear IF, arm.
  - 2: read/write control: bit0 IE, bit1 FREE (free-run); bits 7:2 read 0.
  - 3: read status {IF, 6'b0, armed}; write with Din[7]=1 clears IF, Din[7]=0 no effect.
- Reset (async):
  - latch = counter = RESET_LATCH.
  - IE=0, FREE=0, IF=0, armed=0.
  - Dout=8'h00, nIRQ=1.
- Read path:
  - On riseE with CS&RnW, Dout <= selected register.
  - Without CS&RnW, Dout holds its value.
- Write path and side effects:
  - Applied only on fallE with CS.
  - Nothing happens outside fallE, even when CS/ADDR change.
- Counting: on every fallE, counter decrements by 1 (mod 2^16). Exception: no decrement on the fallE that loads via ADDR 1.
- Underflow is the fallE where counter==0 before decrement:
  - FREE=1: counter <= latch (no wrap to FFFF); IF <= 1.
  - FREE=0 and armed=1: counter <= FFFF; IF <= 1; armed <= 0.
  - FREE=0 and armed=0: counter <= FFFF; IF unchanged (one interrupt per load).
- Simultaneous events on the same fallE:
  - Load (write ADDR 1) beats underflow: counter loaded, IF=0, armed=1.
  - Underflow set beats clear by read of ADDR 0 or status write: IF=1.
  - Write latch[7:0] during free-run underflow: the reload uses the old latch, and the new latch takes effect at the next reload.
- Read data captured at riseE is the pre-fallE value. The counter therefore reads as the value before that cycle's decrement.
- nIRQ:
  - Equals ~(IF & IE), registered when IRQ_REG=1, so it goes low one CLK after the fallE that sets IF.
  - Clearing IE releases nIRQ without clearing IF.
- Reset mid-operation: all state returns to reset values immediately, and nIRQ deasserts asynchronously.
- Widths: counter and latch are 16 bit, with all arithmetic modulo 2^16.

Test Plan:
- Reset → Dout=00, nIRQ=1; read status = 00, read ADDR1 after riseE = FF.
- IE=1, FREE=0, write latch lo 03, write hi 00 → counter 0003,0002,0001,0000 on successive fallE. The 5th fallE after load sets IF and counter=FFFF. nIRQ low one CLK later. Read ADDR0 → nIRQ high. No second IRQ after FFFF→…→0000 wrap.
- FREE=1, latch=0002 → IF sets every 3 fallE (0002→0001→0000→reload 0002). After each IF, write status 80 to clear, and nIRQ pulses each period.
- Write ADDR1 on the same fallE as underflow → IF stays 0, counter = new load value, armed=1.
- Read ADDR0 on the same fallE as underflow → IF=1, nIRQ asserted.
- Accesses with CS=0, and writes without fallE strobe → no register change. Assert RESET mid-count → all outputs to reset values within the same CLK.
